// File: rtl/nrdiv8_ctrl.sv
// Unsigned 8-bit non-restoring divider controller driving a shared 9-bit CAS add/subtract datapath.
// One quotient bit per cycle, a single remainder-correction cycle, then a one-cycle done pulse.
module nrdiv8_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] dividend,
    input  logic [7:0] divisor,
    output logic       busy,
    output logic       done,
    output logic [7:0] quotient,
    output logic [7:0] remainder,
    output logic       div_by_zero
);
    localparam int unsigned W  = 8;
    localparam int unsigned RW = W + 1;
    localparam int unsigned CW = 3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_CORR = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          state, state_n;
    logic [RW-1:0]   r, r_n;
    logic [W-1:0]    q, q_n;
    logic [W-1:0]    d, d_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [W-1:0]    quot_n, rem_n;
    logic            dbz_n, busy_n, done_n;

    logic [RW-1:0]   cas_a, cas_b, cas_sum;
    logic            cas_ctrl;

    // Shared CAS datapath: ctrl=1 subtracts (B inverted, carry-in 1), ctrl=0 adds.
    // ITER feeds the shifted remainder; CORR feeds R itself with an add.
    assign cas_a    = (state == S_CORR) ? r : {r[W-1:0], q[W-1]};
    assign cas_ctrl = (state == S_CORR) ? 1'b0 : ~r[W];
    assign cas_b    = {1'b0, d};
    assign cas_sum  = cas_a + (cas_b ^ {RW{cas_ctrl}}) + RW'(cas_ctrl);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            r           <= '0;
            q           <= '0;
            d           <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_n;
            r           <= r_n;
            q           <= q_n;
            d           <= d_n;
            cnt         <= cnt_n;
            quotient    <= quot_n;
            remainder   <= rem_n;
            div_by_zero <= dbz_n;
            busy        <= busy_n;
            done        <= done_n;
        end
    end

    // Next-state and next-register values; busy/done are registered from the current state.
    always_comb begin
        state_n = state;
        r_n     = r;
        q_n     = q;
        d_n     = d;
        cnt_n   = cnt;
        quot_n  = quotient;
        rem_n   = remainder;
        dbz_n   = div_by_zero;
        busy_n  = 1'b0;
        done_n  = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    if (divisor != '0) begin
                        r_n     = '0;
                        q_n     = dividend;
                        d_n     = divisor;
                        cnt_n   = '0;
                        state_n = S_ITER;
                    end else begin
                        quot_n  = {W{1'b1}};
                        rem_n   = dividend;
                        dbz_n   = 1'b1;
                        state_n = S_DONE;
                    end
                end
            end
            S_ITER: begin
                busy_n = 1'b1;
                r_n    = cas_sum;
                q_n    = {q[W-2:0], ~cas_sum[W]};
                cnt_n  = cnt + CW'(1);
                if (cnt == CW'(W - 1)) begin
                    state_n = S_CORR;
                end
            end
            S_CORR: begin
                busy_n = 1'b1;
                if (r[W]) begin
                    r_n = cas_sum;
                end
                quot_n  = q;
                rem_n   = r[W] ? cas_sum[W-1:0] : r[W-1:0];
                dbz_n   = 1'b0;
                state_n = S_DONE;
            end
            S_DONE: begin
                done_n  = 1'b1;
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_nrdiv8_ctrl.sv
// Self-checking bench for nrdiv8_ctrl: directed vector table, multi-cycle corner sequences,
// and a random sweep, with results checked by a done-triggered scoreboard.
module tb_nrdiv8_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       dbz;
    } exp_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] eq;
        logic [7:0] er;
        logic       edbz;
        int         lat;
    } vec_t;

    exp_t sb[$];

    nrdiv8_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard: every done pulse pops one expected result.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_quotient", int'(quotient), int'(e.q));
                check("sb_remainder", int'(remainder), int'(e.r));
                check("sb_div_by_zero", int'(div_by_zero), int'(e.dbz));
            end
        end
    end

    // One start pulse, then watch 12 cycles for done latency, busy length and held results.
    task automatic do_div(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] eq, input logic [7:0] er,
                          input logic edbz, input int lat, input string tag);
        int done_at;
        int busy_cnt;
        exp_t e;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        e.q = eq; e.r = er; e.dbz = edbz;
        sb.push_back(e);
        @(negedge clk);
        start    = 1'b0;
        done_at  = -1;
        busy_cnt = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done && done_at < 0) done_at = k;
        end
        check({tag, "_latency"}, done_at, lat);
        check({tag, "_busy_cycles"}, busy_cnt, (lat == 1) ? 0 : 9);
        check({tag, "_quotient_held"}, int'(quotient), int'(eq));
        check({tag, "_remainder_held"}, int'(remainder), int'(er));
    endtask

    initial begin
        vec_t vecs[$];
        int   ndone;
        int   done_at;
        logic [7:0] ra, rb;

        vecs.push_back('{8'd100, 8'd7,   8'd14,  8'd2,   1'b0, 10});
        vecs.push_back('{8'd255, 8'd1,   8'd255, 8'd0,   1'b0, 10});
        vecs.push_back('{8'd5,   8'd9,   8'd0,   8'd5,   1'b0, 10});
        vecs.push_back('{8'd255, 8'd255, 8'd1,   8'd0,   1'b0, 10});
        vecs.push_back('{8'd200, 8'd0,   8'hFF,  8'hC8,  1'b1, 1});
        vecs.push_back('{8'd13,  8'd3,   8'd4,   8'd1,   1'b0, 10});
        vecs.push_back('{8'd0,   8'd5,   8'd0,   8'd0,   1'b0, 10});
        vecs.push_back('{8'd1,   8'd255, 8'd0,   8'd1,   1'b0, 10});
        vecs.push_back('{8'd128, 8'd2,   8'd64,  8'd0,   1'b0, 10});
        vecs.push_back('{8'd254, 8'd127, 8'd2,   8'd0,   1'b0, 10});

        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_quotient", int'(quotient), 0);
        check("reset_remainder", int'(remainder), 0);
        check("reset_div_by_zero", int'(div_by_zero), 0);

        foreach (vecs[i]) begin
            do_div(vecs[i].a, vecs[i].b, vecs[i].eq, vecs[i].er, vecs[i].edbz,
                   vecs[i].lat, $sformatf("vec%0d", i));
        end

        // Start held and operands changed during busy and DONE: only the first request counts.
        @(negedge clk);
        dividend = 8'd100; divisor = 8'd7; start = 1'b1;
        sb.push_back('{8'd14, 8'd2, 1'b0});
        ndone = 0; done_at = -1;
        for (int k = 0; k <= 24; k++) begin
            @(negedge clk);
            if (k >= 1 && done) begin
                ndone++;
                if (done_at < 0) done_at = k;
            end
            if (k <= 9) begin
                start    = 1'b1;
                dividend = (k % 2 == 1) ? 8'd50 : 8'($urandom);
                divisor  = (k % 2 == 1) ? 8'd5  : 8'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        check("ovl_done_count", ndone, 1);
        check("ovl_latency", done_at, 10);
        check("ovl_quotient_held", int'(quotient), 14);
        check("ovl_remainder_held", int'(remainder), 2);

        // Reset at iteration 4 aborts the division with no done pulse.
        @(negedge clk);
        dividend = 8'd100; divisor = 8'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_quotient", int'(quotient), 0);
        check("abort_remainder", int'(remainder), 0);
        check("abort_div_by_zero", int'(div_by_zero), 0);
        ndone = 0;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        check("abort_no_activity", ndone, 0);
        do_div(8'd13, 8'd3, 8'd4, 8'd1, 1'b0, 10, "post_abort");

        // Start coincident with reset is dropped.
        @(negedge clk);
        rst = 1'b1; start = 1'b1; dividend = 8'd10; divisor = 8'd2;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        check("rst_start_ignored", ndone, 0);
        check("rst_start_quotient", int'(quotient), 0);

        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom_range(1, 255));
            do_div(ra, rb, ra / rb, ra % rb, 1'b0, 10, "rand");
        end

        check("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
